button_debounce: RTL



---
 rtl/button_debounce_pkg.sv | 22 ++
 rtl/button_debounce_if.sv | 25 ++
 rtl/button_debounce_chan.sv | 116 +++++++++++
 rtl/button_debounce.sv | 57 +++++
 4 files changed

// File: rtl/button_debounce_pkg.sv
// Shared constants, per-channel event bundle and pin polarity helper for button_debounce.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package button_pkg;

  localparam int DB_CNT_W   = 8;
  localparam int HOLD_CNT_W = 16;

  // Everything one debounced channel reports in a given cycle.
  typedef struct packed {
    logic level;
    logic press;
    logic rel;
    logic long_ev;
  } btn_evt_t;

  // Idle (not pressed) pin level for a given polarity.
  function automatic logic released_val(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/button_debounce_if.sv
// Bundles raw button pins with their debounced levels and event pulses.
// Latency: n/a (wiring only).
// Backpressure: none; every output is a level or a one-cycle pulse.
interface button_debounce_if #(
  parameter int N_BTN = 2
);
  logic [N_BTN-1:0] i_BTN;
  logic [N_BTN-1:0] o_BTN_LEVEL;
  logic [N_BTN-1:0] o_PRESS;
  logic [N_BTN-1:0] o_RELEASE;
  logic [N_BTN-1:0] o_LONG;
  logic             o_TICK;

  // Board / test side: drives pins, observes events.
  modport master (
    output i_BTN,
    input  o_BTN_LEVEL, o_PRESS, o_RELEASE, o_LONG, o_TICK
  );

  // Debouncer side.
  modport slave (
    input  i_BTN,
    output o_BTN_LEVEL, o_PRESS, o_RELEASE, o_LONG, o_TICK
  );
endinterface

// File: rtl/button_debounce_chan.sv
// One button channel: 2-FF synchronizer, tick-counted debounce, press/release pulses, optional hold counter (LONG_PRESS_EN).
// Latency: pulse 2+(DB_TICKS-1)*tick_period+1 .. 2+DB_TICKS*tick_period cycles after a raw edge.
// Backpressure: none; pulses are one cycle wide and never stall.
module debounce_chan
  import button_pkg::*;
#(
  parameter int DB_TICKS   = 16,
  parameter int LONG_TICKS = 1000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     tick_i,
  input  logic     pin_i,
  output btn_evt_t evt_o
);

  localparam logic                PIN_IDLE = released_val(ACTIVE_LOW);
  localparam logic [DB_CNT_W-1:0] DB_LAST  = DB_CNT_W'(DB_TICKS - 1);

  logic                sync1_q, sync2_q, sync_val;
  logic [DB_CNT_W-1:0] cnt_q, cnt_d;
  logic                level_q, level_d;
  logic                press_q, press_d;
  logic                rel_q, rel_d;
  logic                long_w;

  // Two-flop synchronizer; resets to the idle pin level so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= PIN_IDLE;
      sync2_q <= PIN_IDLE;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
    end
  end

  // Internal logic is active-high regardless of pin polarity.
  assign sync_val = sync2_q ^ ACTIVE_LOW;

  // Debounce: count consecutive mismatching ticks; any match wipes the count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (sync_val != level_q) begin
      cnt_d = cnt_q;
      if (tick_i) begin
        if (cnt_q == DB_LAST) begin
          cnt_d   = '0;
          level_d = sync_val;
          press_d = sync_val;
          rel_d   = ~sync_val;
        end else begin
          cnt_d = cnt_q + DB_CNT_W'(1);
        end
      end
    end
  end

  // Debounce state and event pulses share one edge so level and pulse line up.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

`ifdef LONG_PRESS_EN
  localparam logic [HOLD_CNT_W-1:0] HOLD_MAX = HOLD_CNT_W'(LONG_TICKS);

  logic [HOLD_CNT_W-1:0] hold_q, hold_d;
  logic                  long_q, long_d;

  // Hold counter: ticks while pressed, saturates so the long event fires once per hold.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (!level_q) begin
      hold_d = '0;
    end else if (tick_i && (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + HOLD_CNT_W'(1);
      long_d = (hold_q == HOLD_MAX - HOLD_CNT_W'(1));
    end
  end

  // Hold counter and long-press pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_w = long_q;
`else
  logic unused_long_ticks;
  assign unused_long_ticks = ^HOLD_CNT_W'(LONG_TICKS);
  assign long_w = 1'b0;
`endif

  assign evt_o = '{level: level_q, press: press_q, rel: rel_q, long_ev: long_w};

endmodule

// File: rtl/button_debounce.sv
// Debounces N_BTN raw pushbuttons off one shared prescaler tick; long-press events when LONG_PRESS_EN is defined.
// Latency: 2-FF sync plus DB_TICKS debounce ticks (each 2^PRESCALE_W cycles) from raw edge to pulse.
// Backpressure: none; outputs are levels and one-cycle pulses.
module button_debounce
  import button_pkg::*;
#(
  parameter int N_BTN      = 2,
  parameter int PRESCALE_W = 10,
  parameter int DB_TICKS   = 16,
  parameter int LONG_TICKS = 1000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  button_debounce_if.slave   btn_if
);

  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic                  tick_w;
  btn_evt_t              evt [N_BTN];
  logic [N_BTN-1:0]      level_w, press_w, rel_w, long_w;

  assign presc_d = presc_q + PRESCALE_W'(1);

  // Free-running prescaler; wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) presc_q <= '0;
    else       presc_q <= presc_d;
  end

  assign tick_w = &presc_q;

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    debounce_chan #(
      .DB_TICKS  (DB_TICKS),
      .LONG_TICKS(LONG_TICKS),
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_chan (
      .clk   (clk),
      .reset (reset),
      .tick_i(tick_w),
      .pin_i (btn_if.i_BTN[g]),
      .evt_o (evt[g])
    );
    assign level_w[g] = evt[g].level;
    assign press_w[g] = evt[g].press;
    assign rel_w[g]   = evt[g].rel;
    assign long_w[g]  = evt[g].long_ev;
  end

  assign btn_if.o_BTN_LEVEL = level_w;
  assign btn_if.o_PRESS     = press_w;
  assign btn_if.o_RELEASE   = rel_w;
  assign btn_if.o_LONG      = long_w;
  assign btn_if.o_TICK      = tick_w;

endmodule
